// File: rtl/rx_regfile_dump.sv
// Parametrised register file with N combinational read ports, one write port and a
// valid/ready dump engine. Define RF_BYPASS_EN for same-cycle write-to-read forwarding.
module rx_regfile_dump #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_R0  = 1,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     dump_start,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [ADDR_W-1:0]        dump_idx,
    output logic [DATA_W-1:0]        dump_data,
    output logic                     dump_busy,
    output logic                     dump_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              wr_fire;
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] dump_val;

    // Writes to a hardwired-zero r0 are dropped here, so forwarding never sees them either.
    assign wr_fire = wr_en && !(ZERO_R0 != 0 && wr_addr == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_fire) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] val;

        assign addr = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            val = regs_q[addr];
`ifdef RF_BYPASS_EN
            if (wr_fire && addr == wr_addr) begin
                val = wr_data;
            end
`endif
            if (ZERO_R0 != 0 && addr == '0) begin
                val = '0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = val;
    end

    always_comb begin
        dump_val = regs_q[idx_q];
`ifdef RF_BYPASS_EN
        if (wr_fire && idx_q == wr_addr) begin
            dump_val = wr_data;
        end
`endif
        if (ZERO_R0 != 0 && idx_q == '0) begin
            dump_val = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (dump_start) begin
                    state_d = S_STREAM;
                    idx_d   = '0;
                end
            end
            S_STREAM: begin
                if (dump_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Index and data are masked outside STREAM so idle outputs read as zero.
    always_comb begin
        dump_valid = 1'b0;
        dump_busy  = 1'b0;
        dump_done  = 1'b0;
        dump_idx   = '0;
        dump_data  = '0;
        case (state_q)
            S_STREAM: begin
                dump_valid = 1'b1;
                dump_busy  = 1'b1;
                dump_idx   = idx_q;
                dump_data  = dump_val;
            end
            S_DONE:  dump_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rx_regfile_dump.sv
// Directed bench for rx_regfile_dump: reset, read/write, r0 rule, dump with
// backpressure, writes during a dump and reset mid-dump.
module tb_rx_regfile_dump;

    localparam int unsigned NR = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [2*AW-1:0] rd_addr;
    logic [2*DW-1:0] rd_data, rd_data_nz;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          dump_start, dump_ready, dump_valid, dump_busy, dump_done;
    logic [AW-1:0] dump_idx;
    logic [DW-1:0] dump_data;
    logic          start_nz, ready_nz, valid_nz, busy_nz, done_nz;
    logic [AW-1:0] idx_nz;
    logic [DW-1:0] data_nz;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rx_regfile_dump #(.NUM_REGS(NR), .DATA_W(DW), .NUM_RD(2), .ZERO_R0(1)) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_idx(dump_idx), .dump_data(dump_data), .dump_busy(dump_busy),
        .dump_done(dump_done)
    );

    rx_regfile_dump #(.NUM_REGS(NR), .DATA_W(DW), .NUM_RD(2), .ZERO_R0(0)) dut_nz (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_nz),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .dump_start(start_nz), .dump_valid(valid_nz), .dump_ready(ready_nz),
        .dump_idx(idx_nz), .dump_data(data_nz), .dump_busy(busy_nz),
        .dump_done(done_nz)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive ready, check the current beat, advance to next negedge.
    task automatic beat(input string tag, input logic rdy, input int unsigned eidx,
                        input logic [31:0] edata);
        dump_ready = rdy;
        #1;
        chk({tag, "_valid"}, 32'(dump_valid), 32'd1);
        chk({tag, "_idx"}, 32'(dump_idx), 32'(eidx));
        chk({tag, "_data"}, dump_data, edata);
        @(negedge clk);
    endtask

    function automatic logic [31:0] pre(input int unsigned i);
        return 32'(i * 32'h0101_0101);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int unsigned exp_idx;
        int unsigned cyc;

        rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        dump_start = 1'b0; dump_ready = 1'b0; start_nz = 1'b0; ready_nz = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset clears a written register
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        wr_en = 1'b0; rd_addr = {5'd0, 5'd5};
        #1 chk("r5_written", rd_data[31:0], 32'hDEAD_BEEF);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_r5", rd_data[31:0], 32'h0);
        chk("rst_busy", 32'(dump_busy), 32'd0);
        chk("rst_valid", 32'(dump_valid), 32'd0);
        chk("rst_done", 32'(dump_done), 32'd0);
        chk("rst_idx", 32'(dump_idx), 32'd0);
        chk("rst_data", dump_data, 32'h0);
        @(negedge clk);

        // Back-to-back writes, read on two ports
        rd_addr = {5'd2, 5'd1};
        wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h1111_1111;
        @(negedge clk);
        wr_addr = 5'd2; wr_data = 32'h2222_2222;
        #1;
        chk("r1_after_write", rd_data[31:0], 32'h1111_1111);
        chk("r2_write_cycle", rd_data[63:32], BYP ? 32'h2222_2222 : 32'h0);
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        chk("rd_p0_r1", rd_data[31:0], 32'h1111_1111);
        chk("rd_p1_r2", rd_data[63:32], 32'h2222_2222);

        // r0 write: dropped with ZERO_R0=1, stored with ZERO_R0=0
        rd_addr = {5'd0, 5'd0};
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
        #1;
        chk("r0_write_cycle", rd_data[31:0], 32'h0);
        chk("r0_nz_write_cycle", rd_data_nz[31:0], BYP ? 32'hFFFF_FFFF : 32'h0);
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        chk("r0_zero_p0", rd_data[31:0], 32'h0);
        chk("r0_zero_p1", rd_data[63:32], 32'h0);
        chk("r0_nz", rd_data_nz[31:0], 32'hFFFF_FFFF);
        @(negedge clk);

        for (int unsigned i = 1; i < NR; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = pre(i);
            @(negedge clk);
        end
        wr_en = 1'b0;

        // Dump with ready toggling; a stray dump_start mid-stream must be ignored
        dump_start = 1'b1;
        #1 chk("idle_valid", 32'(dump_valid), 32'd0);
        @(negedge clk);
        exp_idx = 0;
        cyc = 0;
        while (exp_idx < NR && cyc < 200) begin
            dump_start = (cyc == 7);
            dump_ready = (cyc % 2 == 1);
            #1;
            chk("bp_valid", 32'(dump_valid), 32'd1);
            chk("bp_busy", 32'(dump_busy), 32'd1);
            chk("bp_done", 32'(dump_done), 32'd0);
            chk("bp_idx", 32'(dump_idx), 32'(exp_idx));
            chk("bp_data", dump_data, pre(exp_idx));
            if (dump_ready) exp_idx++;
            cyc++;
            @(negedge clk);
        end
        dump_ready = 1'b0;
        chk("bp_cycles", 32'(cyc), 32'd64);
        // DONE cycle: dump_start here must not restart the engine
        dump_start = 1'b1;
        #1;
        chk("done_pulse", 32'(dump_done), 32'd1);
        chk("done_valid", 32'(dump_valid), 32'd0);
        chk("done_busy", 32'(dump_busy), 32'd0);
        @(negedge clk);
        #1;
        chk("after_done", 32'(dump_done), 32'd0);
        chk("after_done_valid", 32'(dump_valid), 32'd0);
        @(negedge clk);
        dump_start = 1'b0;

        // Writes while streaming
        beat("wd0", 1'b1, 0, 32'h0);
        beat("wd1", 1'b1, 1, 32'h0101_0101);
        beat("wd2", 1'b1, 2, 32'h0202_0202);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFE_0003;
        beat("wd3_wr", 1'b0, 3, BYP ? 32'hCAFE_0003 : 32'h0303_0303);
        wr_addr = 5'd10; wr_data = 32'hABCD_000A;
        beat("wd3_new", 1'b1, 3, 32'hCAFE_0003);
        wr_addr = 5'd4; wr_data = 32'h4444_0004;
        beat("wd4_same", 1'b1, 4, BYP ? 32'h4444_0004 : 32'h0404_0404);
        wr_en = 1'b0;
        for (int unsigned i = 5; i < 10; i++) beat("wd_mid", 1'b1, i, pre(i));
        beat("wd10", 1'b1, 10, 32'hABCD_000A);
        for (int unsigned i = 11; i < NR; i++) beat("wd_tail", 1'b1, i, pre(i));
        dump_ready = 1'b0;
        #1 chk("wd_done", 32'(dump_done), 32'd1);
        @(negedge clk);
        rd_addr = {5'd4, 5'd3};
        #1;
        chk("rd_r3_after", rd_data[31:0], 32'hCAFE_0003);
        chk("rd_r4_after", rd_data[63:32], 32'h4444_0004);

        // Reset during a dump
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        for (int unsigned i = 0; i < 7; i++) begin
            beat("rm", 1'b1, i, (i == 3) ? 32'hCAFE_0003 : (i == 4) ? 32'h4444_0004 : pre(i));
        end
        dump_ready = 1'b0;
        #1 chk("rm_idx7", 32'(dump_idx), 32'd7);
        reset = 1'b1;
        #1;
        chk("rm_valid_async", 32'(dump_valid), 32'd0);
        chk("rm_busy_async", 32'(dump_busy), 32'd0);
        chk("rm_done_async", 32'(dump_done), 32'd0);
        for (int unsigned i = 0; i < 2; i++) begin
            @(negedge clk);
            #1 chk("rm_no_done", 32'(dump_done), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("rm_rel_done", 32'(dump_done), 32'd0);
        chk("rm_rel_valid", 32'(dump_valid), 32'd0);
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        for (int unsigned i = 0; i < NR; i++) beat("post_rst", 1'b1, i, 32'h0);
        dump_ready = 1'b0;
        #1 chk("post_rst_done", 32'(dump_done), 32'd1);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rx_regfile_dump.md
Name: rx_regfile_dump

Overview:
- Parametrised register file for the cpu core, the next generation of the fixed 32x32 rx array.
- Configurable depth, width and read-port count; one write port; optional hardwired-zero r0.
- Adds a hardware dump engine that streams every register out over a valid/ready channel, so benches and debug logic read architectural state without hierarchical peeks.
- Sits inside the cpu beside the decode/execute datapath; the dump channel goes to the debug/trace logic.

Parameters:
- NUM_REGS, 32, number of registers; power of two, >=2
- DATA_W, 32, register width in bits
- NUM_RD, 2, number of combinational read ports, 1..4
- ZERO_R0, 1, 1 = register 0 reads as 0 and ignores writes
- ADDR_W, $clog2(NUM_REGS), index width; derived, do not override

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W]
- wr_en  in  1  write enable
- wr_addr  in  ADDR_W  write index
- wr_data  in  DATA_W  write data
- dump_start  in  1  single-cycle request to begin a dump
- dump_valid  out  1  dump beat valid
- dump_ready  in  1  consumer accepts beat
- dump_idx  out  ADDR_W  index of the current beat
- dump_data  out  DATA_W  register value of the current beat
- dump_busy  out  1  dump in progress
- dump_done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (asynchronous assert, sampled deassert): all registers 0; FSM to IDLE; dump_valid, dump_busy, dump_done, dump_idx and dump_data all 0.
- Write:
  - when wr_en=1 at the rising edge, regs[wr_addr] <= wr_data.
  - if ZERO_R0=1 and wr_addr=0, the write is dropped.
- Read:
  - combinational: rd_data[k] = regs[rd_addr[k]].
  - register 0 returns 0 when ZERO_R0=1.
  - without bypass, a write is visible on the cycle after the edge.
  - several ports may read the same address.
- Dump FSM states: IDLE, STREAM, DONE.
  - IDLE: dump_start=1 -> STREAM, idx=0.
  - STREAM:
    - dump_valid=1, dump_busy=1, dump_idx=idx.
    - dump_data = current regs[idx], live and including the r0 rule.
    - valid&&ready with idx<NUM_REGS-1 -> idx+1.
    - valid&&ready with idx=NUM_REGS-1 -> DONE.
    - dump_ready=0 holds idx.
  - DONE: dump_done=1, dump_busy=0, dump_valid=0 for exactly one cycle, then IDLE.
  - dump_start is ignored in STREAM and DONE. It is honoured in IDLE only, including the cycle right after DONE.
- Simultaneous write and dump handshake on the same index: the beat carries the old (pre-edge) value. Without bypass, a later beat of that index sees the new value.
- Dump never stalls or blocks the read/write ports.
- Reset asserted mid-dump: immediate abort to IDLE, with no dump_done pulse.
- dump_valid never drops without a handshake, except on reset.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined:
  - write-to-read forwarding: if wr_en=1 and rd_addr[k]=wr_addr (and not the zeroed r0), rd_data[k]=wr_data in the same cycle.
  - the same forwarding applies to dump_data when dump_idx=wr_addr.
- Undefined: reads and dump_data see only stored values; a write is visible one cycle later.

Test Plan:
- Reset: hold reset=1 for 2 cycles after writing 0xDEADBEEF to r5 -> after release, rd_data port0 at addr 5 = 0; dump_busy=0, dump_valid=0.
- Write/read: write r1=0x11111111 and r2=0x22222222 on consecutive cycles; read ports 0/1 at addrs 1/2 -> 0x11111111/0x22222222 on the cycle after the second write. With RF_BYPASS_EN, r2 is visible on the write cycle.
- Zero register: ZERO_R0=1, write r0=0xFFFFFFFF -> read r0 = 0, dump beat idx0 = 0. With ZERO_R0=0 -> reads 0xFFFFFFFF.
- Dump with backpressure:
  - preload r[i]=i*0x01010101 (r0=0); pulse dump_start; toggle dump_ready 1/0 each cycle.
  - -> 32 beats, idx 0..31 in order, data matches, each beat held while ready=0.
  - -> dump_done pulses once, 1 cycle after beat 31 is accepted; dump_start during the stream is ignored.
- Write during dump: stall with ready=0 at idx 3; write r3=0xCAFE0003 -> dump_data shows 0xCAFE0003 next cycle (same cycle with RF_BYPASS_EN); write r10=0xABCD000A before idx reaches 10 -> beat 10 = 0xABCD000A.
- Reset mid-dump: assert reset at idx 7 -> dump_valid and dump_busy drop asynchronously, no dump_done pulse; a new dump_start after release streams from idx 0 with all data 0.
